game_sequencer: RTL and testbench

- Top-level game controller for Dino-Jump. Runs on the 50 MHz clock and sequences the engine, score counter and sprite layer through a four-state FSM: IDLE, RUNNING, PAUSED, GAME_OVER.
- Replaces gated game clocks with single-cycle clock enables: tick, jump_req and clear.
- Synchronises and debounces the jump key, synchronises the pause switch, and accepts the engine's collision flag.

---
 rtl/game_sequencer.sv | 156 +++++++++++++++
 tb/tb_game_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Dino-Jump top-level sequencer: IDLE/RUNNING/PAUSED/GAME_OVER FSM driving single-cycle enables.
// Latency: key press -> press_evt 2+DEBOUNCE_CYCLES cycles, FSM outputs one cycle later; no backpressure.
module game_sequencer #(
  parameter int TICK_DIV        = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OVER_HOLD_TICKS = 10
) (
  input  logic       clk50MHz,
  input  logic       reset,
  input  logic       jump_n,
  input  logic       pause,
  input  logic       collision,
  output logic [1:0] state,
  output logic       run,
  output logic       tick,
  output logic       jump_req,
  output logic       clear
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(OVER_HOLD_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD_TICKS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    PAUSED    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t cur_state, next_state;

  logic jump_meta, jump_sync, pause_meta, pause_sync;
  logic key_db;
  logic [DEB_W-1:0] deb_cnt;
  logic press_evt;
  logic [DIV_W-1:0] div_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic div_wrap;
  logic clear_next, jump_next, tick_next;

  // Synchronisers reset to the inactive level of each input (jump_n is active-low).
  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      jump_meta  <= 1'b1;
      jump_sync  <= 1'b1;
      pause_meta <= 1'b0;
      pause_sync <= 1'b0;
    end else begin
      jump_meta  <= jump_n;
      jump_sync  <= jump_meta;
      pause_meta <= pause;
      pause_sync <= pause_meta;
    end
  end

  // key_db holds the accepted key level, 1 = released.
  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      deb_cnt   <= '0;
      key_db    <= 1'b1;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (jump_sync == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        key_db    <= jump_sync;
        press_evt <= ~jump_sync;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign div_wrap = (div_cnt == DIV_LAST);

  always_comb begin
    next_state = cur_state;
    clear_next = 1'b0;
    jump_next  = 1'b0;
    case (cur_state)
      IDLE: begin
        if (press_evt) begin
          next_state = RUNNING;
          clear_next = 1'b1;
        end
      end
      RUNNING: begin
        if (collision)       next_state = GAME_OVER;
        else if (pause_sync) next_state = PAUSED;
        else if (press_evt)  jump_next  = 1'b1;
      end
      PAUSED: begin
        if (!pause_sync) next_state = RUNNING;
      end
      GAME_OVER: begin
        if (press_evt && (hold_cnt == HOLD_MAX)) begin
          next_state = RUNNING;
          clear_next = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    tick_next = div_wrap && (cur_state == RUNNING) && (next_state == RUNNING);
  end

  // Divider restarts with clear, so the clear cycle always sees div_cnt == 0.
  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear_next) begin
      div_cnt <= '0;
    end else begin
      case (cur_state)
        IDLE:    div_cnt <= '0;
        PAUSED:  div_cnt <= div_cnt;
        default: div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if ((cur_state == RUNNING) && (next_state == GAME_OVER)) begin
      hold_cnt <= '0;
    end else if ((cur_state == GAME_OVER) && div_wrap && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      cur_state <= IDLE;
      run       <= 1'b0;
      tick      <= 1'b0;
      jump_req  <= 1'b0;
      clear     <= 1'b0;
    end else begin
      cur_state <= next_state;
      run       <= (next_state == RUNNING);
      tick      <= tick_next;
      jump_req  <= jump_next;
      clear     <= clear_next;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed table, corner sequences, then random traffic
// compared every cycle against a history-based reference model.
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HT = 2;

  logic       clk50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       jump_n = 1'b1;
  logic       pause = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] state;
  logic       run, tick, jump_req, clear;

  always #10 clk50MHz = ~clk50MHz;

  game_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .OVER_HOLD_TICKS(HT)) dut (
    .clk50MHz (clk50MHz),
    .reset    (reset),
    .jump_n   (jump_n),
    .pause    (pause),
    .collision(collision),
    .state    (state),
    .run      (run),
    .tick     (tick),
    .jump_req (jump_req),
    .clear    (clear)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: raw input histories, accepted key level, game mode and counters as plain ints.
  bit m_raw[$];
  bit m_pau[$];
  bit m_sync[$];
  int m_db, m_press, m_st, m_div, m_hold;
  int m_run, m_tick, m_jump, m_clear;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_raw = '{1'b1, 1'b1};
    m_pau = '{1'b0, 1'b0};
    m_sync.delete();
    m_db = 1; m_press = 0; m_st = 0; m_div = 0; m_hold = 0;
    m_run = 0; m_tick = 0; m_jump = 0; m_clear = 0;
  endtask

  task automatic model_step();
    bit sj, sp, all_diff;
    int nx, c, j, t, np;
    if (reset) begin
      model_reset();
      return;
    end
    sj = m_raw[m_raw.size()-2];
    sp = m_pau[m_pau.size()-2];
    m_raw.push_back(jump_n);
    m_pau.push_back(pause);
    if (m_raw.size() > 4) void'(m_raw.pop_front());
    if (m_pau.size() > 4) void'(m_pau.pop_front());
    // The key level is accepted once the last DB synchronised samples all disagree with it.
    np = 0;
    m_sync.push_back(sj);
    if (m_sync.size() > DB) void'(m_sync.pop_front());
    if (m_sync.size() == DB) begin
      all_diff = 1'b1;
      foreach (m_sync[i]) if (int'(m_sync[i]) == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = int'(sj);
        np = (sj == 1'b0) ? 1 : 0;
        m_sync.delete();
      end
    end
    nx = m_st; c = 0; j = 0;
    case (m_st)
      0: if (m_press != 0) begin nx = 1; c = 1; end
      1: if (collision) nx = 3; else if (sp) nx = 2; else if (m_press != 0) j = 1;
      2: if (!sp) nx = 1;
      default: if (m_press != 0 && m_hold == HT) begin nx = 1; c = 1; end
    endcase
    t = (m_st == 1 && nx == 1 && m_div == TD - 1) ? 1 : 0;
    if (m_st == 1 && nx == 3) m_hold = 0;
    else if (m_st == 3 && m_div == TD - 1 && m_hold < HT) m_hold++;
    if (c != 0 || m_st == 0) m_div = 0;
    else if (m_st != 2) m_div = (m_div + 1) % TD;
    m_st = nx; m_run = (nx == 1) ? 1 : 0; m_tick = t; m_jump = j; m_clear = c; m_press = np;
  endtask

  task automatic step_clk();
    int act, exp;
    @(posedge clk50MHz);
    #1;
    cyc++;
    model_step();
    act = (int'(state) << 4) | (int'(run) << 3) | (int'(tick) << 2) | (int'(jump_req) << 1) | int'(clear);
    exp = (m_st << 4) | (m_run << 3) | (m_tick << 2) | (m_jump << 1) | m_clear;
    check("model_outputs", act, exp);
  endtask

  task automatic wait_div(input int v, input string name);
    int w = 0;
    while (m_div != v && w < 2 * TD) begin
      step_clk();
      w++;
    end
    check(name, m_div, v);
  endtask

  typedef struct {
    bit jn; bit pz; bit co;
    int st; bit clr; bit jr; bit tk;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int n, nt, nbad, njr, at, last, clr_at, tk_at;
    tbl = '{
      '{0,0,0, 0,0,0,0}, '{0,0,0, 0,0,0,0}, '{0,0,0, 0,0,0,0}, '{0,0,0, 0,0,0,0},
      '{0,0,0, 0,0,0,0}, '{0,0,0, 1,1,0,0}, '{0,0,0, 1,0,0,0}, '{0,0,0, 1,0,0,0},
      '{0,0,0, 1,0,0,0}, '{0,0,0, 1,0,0,1}, '{1,0,0, 1,0,0,0}, '{1,0,0, 1,0,0,0},
      '{1,0,0, 1,0,0,0}, '{1,0,0, 1,0,0,1}
    };
    model_reset();

    repeat (3) step_clk();
    check("reset_state", int'(state), 0);
    check("reset_run", int'(run), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_jump_req", int'(jump_req), 0);
    check("reset_clear", int'(clear), 0);
    reset = 1'b0;

    // Start-up: key held from the first cycle after reset.
    for (int r = 0; r < 14; r++) begin
      jump_n = tbl[r].jn; pause = tbl[r].pz; collision = tbl[r].co;
      step_clk();
      check($sformatf("tbl%0d_state", r), int'(state), tbl[r].st);
      check($sformatf("tbl%0d_clear", r), int'(clear), int'(tbl[r].clr));
      check($sformatf("tbl%0d_jump_req", r), int'(jump_req), int'(tbl[r].jr));
      check($sformatf("tbl%0d_tick", r), int'(tick), int'(tbl[r].tk));
    end
    repeat (4) step_clk();

    // Tick spacing while running.
    last = -1; nt = 0;
    repeat (16) begin
      step_clk();
      if (tick) begin
        if (last >= 0) check("tick_gap", cyc - last, TD);
        last = cyc; nt++;
      end
    end
    check("tick_count", nt, 4);

    // Short glitch is rejected.
    njr = 0;
    jump_n = 1'b0;
    repeat (2) begin step_clk(); njr += int'(jump_req); end
    jump_n = 1'b1;
    repeat (8) begin step_clk(); njr += int'(jump_req); end
    check("glitch_jump_req", njr, 0);

    // Six-cycle press gives one jump_req.
    njr = 0; at = -1;
    jump_n = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step_clk();
      if (jump_req) begin njr++; at = i; end
      if (i == 6) jump_n = 1'b1;
    end
    check("press_jump_count", njr, 1);
    check("press_jump_at", at, 6);

    // Pause with the divider at 2; press while paused is dropped.
    wait_div(2, "pause_align");
    pause = 1'b1;
    n = 0;
    while (state != 2'd2 && n < 8) begin step_clk(); n++; end
    check("pause_latency", n, 3);
    nt = 0; nbad = 0; njr = 0;
    jump_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step_clk();
      nt += int'(tick); njr += int'(jump_req);
      if (state != 2'd2) nbad++;
      if (i == 6) jump_n = 1'b1;
    end
    check("paused_ticks", nt, 0);
    check("paused_state", nbad, 0);
    pause = 1'b0;
    n = 0;
    while (state != 2'd1 && n < 8) begin step_clk(); n++; end
    check("resume_latency", n, 3);
    at = -1;
    for (int i = 1; i <= 8; i++) begin
      step_clk();
      njr += int'(jump_req);
      if (tick && at < 0) at = i;
    end
    check("resume_first_tick", at, 3);
    check("paused_press_dropped", njr, 0);

    // Collision and press_evt in the same cycle, with the divider at its last value.
    wait_div(2, "collide_align");
    jump_n = 1'b0;
    repeat (5) step_clk();
    check("collide_press_ready", m_press, 1);
    collision = 1'b1;
    step_clk();
    collision = 1'b0;
    check("collide_state", int'(state), 3);
    check("collide_jump_req", int'(jump_req), 0);
    check("collide_tick", int'(tick), 0);
    jump_n = 1'b1;
    repeat (10) step_clk();
    jump_n = 1'b0;
    clr_at = -1; tk_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step_clk();
      if (clear && clr_at < 0) clr_at = i;
      if (tick && tk_at < 0) tk_at = i;
    end
    check("restart_clear_at", clr_at, 6);
    check("restart_state", int'(state), 1);
    check("restart_first_tick", tk_at - clr_at, TD);
    jump_n = 1'b1;
    repeat (6) step_clk();

    // Press too early in GAME_OVER is ignored; pause is ignored there too.
    wait_div(3, "early_align");
    collision = 1'b1;
    step_clk();
    collision = 1'b0;
    check("early_go_state", int'(state), 3);
    jump_n = 1'b0;
    nbad = 0;
    for (int i = 1; i <= 16; i++) begin
      step_clk();
      if (state != 2'd3) nbad++;
      if (i == 6) jump_n = 1'b1;
    end
    check("early_press_ignored", nbad, 0);
    pause = 1'b1;
    nbad = 0; nt = 0;
    repeat (10) begin
      step_clk();
      if (state != 2'd3) nbad++;
      nt += int'(tick);
    end
    pause = 1'b0;
    check("go_pause_state", nbad, 0);
    check("go_pause_tick", nt, 0);
    repeat (4) step_clk();

    // Reset while running with the key held through reset.
    jump_n = 1'b0;
    repeat (8) step_clk();
    check("pre_reset_state", int'(state), 1);
    reset = 1'b1;
    step_clk();
    check("midreset_state", int'(state), 0);
    check("midreset_outputs", int'({run, tick, jump_req, clear}), 0);
    step_clk();
    reset = 1'b0;
    clr_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step_clk();
      if (clear && clr_at < 0) clr_at = i;
    end
    check("post_reset_clear_at", clr_at, 6);
    check("post_reset_state", int'(state), 1);

    // Pause in IDLE is ignored.
    reset = 1'b1;
    step_clk();
    jump_n = 1'b1;
    reset = 1'b0;
    pause = 1'b1;
    nbad = 0; nt = 0;
    repeat (10) begin
      step_clk();
      if (state != 2'd0) nbad++;
      nt += int'(tick);
    end
    pause = 1'b0;
    check("idle_pause_state", nbad, 0);
    check("idle_pause_tick", nt, 0);
    repeat (4) step_clk();

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) jump_n = ~jump_n;
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      collision = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step_clk();
    end
    reset = 1'b0;
    collision = 1'b0;
    step_clk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
